// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode map, instruction field positions, fetch
// state encoding and status flag bit order.
package sisc_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_SWP  = 4'd3;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Status register bit order {C,N,V,Z}
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition decode: whether the branch in IR is taken and whether its
// target is PC-relative.
module sisc_br_cond
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken,
    output logic       is_rel
);

    logic match_s;

    assign match_s = |(mm & stat);

    // Decode the four conditional branch forms; everything else is not taken
    always_comb begin
        taken  = 1'b0;
        is_rel = 1'b0;
        case (opcode)
            OP_BRA: begin taken = match_s;  is_rel = 1'b0; end
            OP_BRR: begin taken = match_s;  is_rel = 1'b1; end
            OP_BNE: begin taken = ~match_s; is_rel = 1'b0; end
            OP_BNR: begin taken = ~match_s; is_rel = 1'b1; end
            default: begin taken = 1'b0; is_rel = 1'b0; end
        endcase
    end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch and branch unit: PC, IR and status register with a
// request/acknowledge fetch against variable-latency instruction memory.
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int AW = 16,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          fetch_go,
    input  logic          br_go,
    input  logic          stat_we,
    input  logic [3:0]    stat_in,
    output logic          im_req,
    output logic [AW-1:0] im_addr,
    input  logic [IW-1:0] im_rdata,
    input  logic          im_ack,
    output logic [AW-1:0] pc,
    output logic [IW-1:0] ir,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic [3:0]    stat,
    output logic          fetch_done,
    output logic          busy
);

    fetch_state_t  state_r;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] im_addr_r;
    logic [IW-1:0] ir_r;
    logic [3:0]    stat_r;
    logic          im_req_r;
    logic          fetch_done_r;
    logic          taken_s;
    logic          is_rel_s;
    logic [AW-1:0] imm_s;
    logic [AW-1:0] target_s;

    sisc_br_cond u_br_cond (
        .opcode (ir_r[OPC_HI:OPC_LO]),
        .mm     (ir_r[MM_HI:MM_LO]),
        .stat   (stat_r),
        .taken  (taken_s),
        .is_rel (is_rel_s)
    );

    assign imm_s = AW'(ir_r[IMM_HI:IMM_LO]);

    // Branch target: absolute immediate or PC plus immediate, carry dropped
    always_comb begin
        if (is_rel_s) begin
            target_s = pc_r + imm_s;
        end else begin
            target_s = imm_s;
        end
    end

    // Fetch FSM with PC, IR, status register and all registered outputs
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r      <= ST_IDLE;
            pc_r         <= '0;
            im_addr_r    <= '0;
            ir_r         <= '0;
            stat_r       <= 4'd0;
            im_req_r     <= 1'b0;
            fetch_done_r <= 1'b0;
        end else begin
            fetch_done_r <= 1'b0;
            if (stat_we) begin
                stat_r <= stat_in;
            end
            case (state_r)
                ST_IDLE: begin
                    // A branch strobe takes priority and drops any fetch request
                    if (br_go) begin
                        if (taken_s) begin
                            pc_r <= target_s;
                        end
                    end else if (fetch_go) begin
                        state_r   <= ST_WAIT;
                        im_req_r  <= 1'b1;
                        im_addr_r <= pc_r;
                    end
                end
                ST_WAIT: begin
                    if (im_ack) begin
                        ir_r         <= im_rdata;
                        pc_r         <= pc_r + AW'(1);
                        fetch_done_r <= 1'b1;
                        im_req_r     <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    im_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc         = pc_r;
    assign ir         = ir_r;
    assign opcode     = ir_r[OPC_HI:OPC_LO];
    assign mm         = ir_r[MM_HI:MM_LO];
    assign stat       = stat_r;
    assign im_req     = im_req_r;
    assign im_addr    = im_addr_r;
    assign fetch_done = fetch_done_r;
    assign busy       = (state_r == ST_WAIT);

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed self-checking bench for sisc_fetch: fetch latency, all branch
// forms, branch/fetch priority, reset abort and status write ordering.
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        fetch_go = 1'b0;
    logic        br_go = 1'b0;
    logic        stat_we = 1'b0;
    logic [3:0]  stat_in = 4'd0;
    logic        im_req;
    logic [15:0] im_addr;
    logic [31:0] im_rdata = 32'd0;
    logic        im_ack = 1'b0;
    logic [15:0] pc;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [3:0]  stat;
    logic        fetch_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sisc_fetch #(.AW(16), .IW(32)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_go   (fetch_go),
        .br_go      (br_go),
        .stat_we    (stat_we),
        .stat_in    (stat_in),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_rdata   (im_rdata),
        .im_ack     (im_ack),
        .pc         (pc),
        .ir         (ir),
        .opcode     (opcode),
        .mm         (mm),
        .stat       (stat),
        .fetch_done (fetch_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] word);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        im_ack   = 1'b1;
        im_rdata = word;
        tick();
        im_ack   = 1'b0;
    endtask

    task automatic set_stat(input logic [3:0] val);
        stat_we = 1'b1;
        stat_in = val;
        tick();
        stat_we = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_stat", 32'(stat), 32'h0);
        chk("rst_req", 32'(im_req), 32'h0);
        chk("rst_addr", 32'(im_addr), 32'h0);
        chk("rst_done", 32'(fetch_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_f = 1'b1;
        tick();

        // Fetch with three-cycle memory latency
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk("f1_req_c1", 32'(im_req), 32'h1);
        chk("f1_addr_c1", 32'(im_addr), 32'h0);
        chk("f1_busy_c1", 32'(busy), 32'h1);
        tick();
        chk("f1_req_c2", 32'(im_req), 32'h1);
        chk("f1_addr_c2", 32'(im_addr), 32'h0);
        chk("f1_done_c2", 32'(fetch_done), 32'h0);
        tick();
        chk("f1_req_c3", 32'(im_req), 32'h1);
        chk("f1_addr_c3", 32'(im_addr), 32'h0);
        chk("f1_ir_c3", ir, 32'h0);
        im_ack   = 1'b1;
        im_rdata = 32'h8123_0000;
        tick();
        im_ack = 1'b0;
        chk("f1_ir", ir, 32'h8123_0000);
        chk("f1_opcode", 32'(opcode), 32'h8);
        chk("f1_mm", 32'(mm), 32'h1);
        chk("f1_pc", 32'(pc), 32'h1);
        chk("f1_done", 32'(fetch_done), 32'h1);
        chk("f1_busy", 32'(busy), 32'h0);
        chk("f1_req_off", 32'(im_req), 32'h0);
        tick();
        chk("f1_done_pulse", 32'(fetch_done), 32'h0);

        // BRA taken then not taken
        set_stat(4'b0001);
        chk("stat_load", 32'(stat), 32'h1);
        do_fetch(32'h4100_00A0);
        chk("bra_pc_pre", 32'(pc), 32'h2);
        br_go = 1'b1;
        tick();
        br_go = 1'b0;
        chk("bra_taken", 32'(pc), 32'h00A0);
        set_stat(4'b0010);
        br_go = 1'b1;
        tick();
        br_go = 1'b0;
        chk("bra_not_taken", 32'(pc), 32'h00A0);

        // Move PC to 0xFFF0 via a taken BRA, then BNR wraps
        do_fetch(32'h4F00_FFEF);
        br_go = 1'b1;
        tick();
        br_go = 1'b0;
        chk("bra_far", 32'(pc), 32'hFFEF);
        do_fetch(32'h7800_0020);
        chk("bnr_pc_pre", 32'(pc), 32'hFFF0);
        set_stat(4'b0000);
        br_go = 1'b1;
        tick();
        br_go = 1'b0;
        chk("bnr_wrap", 32'(pc), 32'h0010);

        // Branch beats fetch in the same cycle
        set_stat(4'b0001);
        do_fetch(32'h4F00_0040);
        chk("pri_pc_pre", 32'(pc), 32'h0011);
        br_go    = 1'b1;
        fetch_go = 1'b1;
        tick();
        br_go    = 1'b0;
        fetch_go = 1'b0;
        chk("pri_pc", 32'(pc), 32'h0040);
        chk("pri_no_req", 32'(im_req), 32'h0);
        chk("pri_no_busy", 32'(busy), 32'h0);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk("pri_next_addr", 32'(im_addr), 32'h0040);
        chk("pri_next_req", 32'(im_req), 32'h1);
        im_ack   = 1'b1;
        im_rdata = 32'h0000_0000;
        tick();
        im_ack = 1'b0;
        chk("pri_next_pc", 32'(pc), 32'h0041);

        // Reset during WAIT, late ack is ignored
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk("rw_req", 32'(im_req), 32'h1);
        #2;
        rst_f = 1'b0;
        #1;
        chk("rw_req_async", 32'(im_req), 32'h0);
        chk("rw_busy_async", 32'(busy), 32'h0);
        tick();
        rst_f = 1'b1;
        tick();
        im_ack   = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        tick();
        im_ack = 1'b0;
        chk("rw_ir", ir, 32'h0);
        chk("rw_pc", 32'(pc), 32'h0);
        chk("rw_done", 32'(fetch_done), 32'h0);
        chk("rw_busy", 32'(busy), 32'h0);

        // stat_we coincident with br_go: branch sees the old stat
        do_fetch(32'h4100_0077);
        stat_we = 1'b1;
        stat_in = 4'b0001;
        br_go   = 1'b1;
        tick();
        stat_we = 1'b0;
        br_go   = 1'b0;
        chk("sw_pc", 32'(pc), 32'h1);
        chk("sw_stat", 32'(stat), 32'h1);

        // BRR taken (relative), BNE not taken
        do_fetch(32'h5100_0010);
        br_go = 1'b1;
        tick();
        br_go = 1'b0;
        chk("brr_taken", 32'(pc), 32'h0012);
        do_fetch(32'h6100_0005);
        br_go = 1'b1;
        tick();
        br_go = 1'b0;
        chk("bne_not_taken", 32'(pc), 32'h0013);

        // Non-branch opcode under br_go leaves PC alone
        do_fetch(32'h8F00_0000);
        br_go = 1'b1;
        tick();
        br_go = 1'b0;
        chk("alu_no_branch", 32'(pc), 32'h0014);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
